buffered_uart_rx: RTL and testbench
===================================

# buffered_uart_rx

Receive-side counterpart of the buffered UART transmitter used for USB debug tracing. Samples an asynchronous 8N1 serial line in the 48 MHz USB clock domain, deframes bytes, and stores them in an internal FIFO. Downstream logic (e.g. the USB IN send-queue filler) pops bytes through a synchronous read-enable interface. Framing and overrun errors are recorded as sticky flags.

## Interface
- CLK_HZ, 48000000, system clock frequency in Hz
- BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 416 at defaults)
- DEPTH_LOG2, 4, FIFO depth = 2^DEPTH_LOG2 bytes (16)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset: synchronous, active-low
- uart_rx  in  1  asynchronous serial input, idle high
- rd_en  in  1  pop request; pops head byte when !empty
- data_out  out  8  FIFO head byte (first-word fall-through), valid while !empty
- empty  out  1  FIFO holds 0 bytes
- full  out  1  FIFO holds 2^DEPTH_LOG2 bytes
- count  out  DEPTH_LOG2+1  bytes currently stored
- frame_err  out  1  sticky: stop bit sampled low
- overrun  out  1  sticky: byte dropped because FIFO full
- clear_err  in  1  clears frame_err and overrun

## Operation
- Input: 2-FF synchronizer on uart_rx, both stages reset to 1; FSM uses second stage (rx_s).
- Bit timer: counter 0..CLKS_PER_BIT-1; half-bit = CLKS_PER_BIT/2 (208).
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
- IDLE: rx_s==0 -> START, timer cleared.
- START: at timer==half-bit-1 sample rx_s; 0 -> DATA (bit index 0, timer cleared); 1 -> IDLE (glitch rejected, nothing recorded).
- DATA: every CLKS_PER_BIT cycles sample rx_s into shift register, LSB first; after bit 7 -> STOP.
- STOP: after CLKS_PER_BIT sample rx_s. 1 -> push byte, -> IDLE. 0 -> frame_err<=1, byte discarded, -> WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then IDLE (break condition produces exactly one frame_err event, no bytes).
- FIFO: 2^DEPTH_LOG2 x 8 array, wr/rd pointers DEPTH_LOG2+1 bits, wrap naturally; empty = ptrs equal; full = low bits equal, MSB differs; count = wr_ptr - rd_ptr.
- Push when full: if rd_en && !empty in the same cycle, pop and push both occur, no overrun; otherwise byte dropped, overrun<=1, FIFO contents unchanged.
- rd_en while empty: ignored, pointers unchanged.
- clear_err: clears both sticky flags; if an error event occurs in the same cycle, the set wins.
- Reset (rst==0): FSM->IDLE, timer/bit index/shift reg 0, pointers 0, frame_err=0, overrun=0, synchronizer=1. Reset mid-frame abandons the byte; next frame needs a fresh falling edge seen from IDLE.

## Timing
- Reset outputs: empty=1, full=0, count=0, frame_err=0, overrun=0, data_out=array[0] (don't-care while empty).
- Synchronizer latency 2 cycles.
- Start sample at half-bit after IDLE sees rx_s low; data bit n sampled (n+1)*CLKS_PER_BIT later; stop sampled 9*CLKS_PER_BIT after start sample.
- Push registered in the stop-sample cycle; empty falls / count increments on the next rising edge.
- Pop: rd_en sampled at edge; data_out/count/empty reflect the pop after that edge (0-cycle read latency for head byte).
- Back-to-back frames: new start bit accepted the cycle after returning to IDLE; tolerates line rate error up to ±2%.
- Flags update one cycle after the triggering sample.

## Test plan
- Single byte 0xA5 at 115200 -> after stop, empty=0, count=1, data_out=0xA5; rd_en one cycle -> empty=1, count=0.
- 16 bytes 0x00..0x0F back-to-back, no reads -> full=1, count=16; read all -> sequence 0x00..0x0F in order, pointers wrap; second burst of 5 reads back correctly.
- 17th byte 0x55 with FIFO full, rd_en=0 -> overrun=1, count stays 16, 0x55 absent; repeat with rd_en pulsed in the push cycle -> overrun stays 0, 0x55 last out.
- Low pulse of 100 cycles on idle line -> no push, no flags, FSM back in IDLE.
- Frame 0x3C with stop bit held low then line low 2000 cycles -> frame_err=1, count unchanged, no extra bytes; next valid 0x7E received; clear_err -> frame_err=0.
- rst low mid-frame (after bit 3) with 2 bytes queued -> empty=1, count=0, flags 0; following frame 0x81 received correctly.

Source files
------------

// File: rtl/buffered_uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : buffered_uart_rx_if
// Description : Serial line, FIFO read port and error-flag bundle for the
//               buffered UART receiver.
//               slave  - receiver side (samples uart_rx, presents FIFO head)
//               master - surrounding logic (drives line, pops bytes)
// Signals     : uart_rx   serial input, idle high
//               rd_en     pop request
//               clear_err clears the sticky error flags
//               data_out  FIFO head byte (first-word fall-through)
//               empty     FIFO holds no bytes
//               full      FIFO holds 2^DEPTH_LOG2 bytes
//               count     number of stored bytes
//               frame_err sticky: stop bit sampled low
//               overrun   sticky: byte dropped, FIFO full
// Revision    : 1.0 - initial release
// ============================================================================
interface buffered_uart_rx_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  uart_rx;
    logic                  rd_en;
    logic                  clear_err;
    logic [7:0]            data_out;
    logic                  empty;
    logic                  full;
    logic [DEPTH_LOG2:0]   count;
    logic                  frame_err;
    logic                  overrun;

    modport slave (
        input  uart_rx,
        input  rd_en,
        input  clear_err,
        output data_out,
        output empty,
        output full,
        output count,
        output frame_err,
        output overrun
    );

    modport master (
        output uart_rx,
        output rd_en,
        output clear_err,
        input  data_out,
        input  empty,
        input  full,
        input  count,
        input  frame_err,
        input  overrun
    );
endinterface
`default_nettype wire

// File: rtl/buffered_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : buffered_uart_rx
// Description : 8N1 UART receiver with synchronizer, deframing FSM and a
//               2^DEPTH_LOG2-byte first-word-fall-through FIFO. Framing and
//               overrun errors are held in sticky flags until clear_err.
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous reset, active low
//               bus  - buffered_uart_rx_if.slave (line, FIFO read, flags)
// Parameters  : CLK_HZ, BAUD (CLKS_PER_BIT = CLK_HZ/BAUD), DEPTH_LOG2
// Revision    : 1.0 - initial release
// ============================================================================
module buffered_uart_rx #(
    parameter int CLK_HZ     = 48000000,
    parameter int BAUD       = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  wire logic           clk,
    input  wire logic           rst,
    buffered_uart_rx_if.slave   bus
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TW           = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int DEPTH        = 1 << DEPTH_LOG2;
    localparam int PW           = DEPTH_LOG2 + 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] TIMER_HALF = TW'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_STOP      = 3'd3,
        S_WAIT_HIGH = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    mem_q [DEPTH];

    // FSM strobes
    logic          push_req;
    logic          stop_bad;

    // FIFO control
    logic          empty_w;
    logic          full_w;
    logic          do_pop;
    logic          do_push;
    logic          ov_set;

    // ------------------------------------------------------------------
    // Synchronizer and deframing FSM
    // ------------------------------------------------------------------
    always_comb begin
        sync1_d   = bus.uart_rx;
        sync2_d   = sync1_q;
        state_d   = state_q;
        timer_d   = timer_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push_req  = 1'b0;
        stop_bad  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!sync2_q) begin
                    state_d = S_START;
                    timer_d = '0;
                end
            end

            S_START: begin
                // Mid-start-bit recheck rejects short glitches on the line.
                if (timer_q == TIMER_HALF) begin
                    timer_d = '0;
                    if (!sync2_q) begin
                        state_d   = S_DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_DATA: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    shift_d = {sync2_q, shift_q[7:1]};  // LSB arrives first
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_STOP: begin
                if (timer_q == TIMER_LAST) begin
                    timer_d = '0;
                    if (sync2_q) begin
                        push_req = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_WAIT_HIGH;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end

            S_WAIT_HIGH: begin
                // A held-low line (break) yields a single frame error.
                if (sync2_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FIFO pointers and sticky flags
    // ------------------------------------------------------------------
    assign empty_w = (wr_ptr_q == rd_ptr_q);
    assign full_w  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[PW-2:0] == rd_ptr_q[PW-2:0]);

    always_comb begin
        do_pop      = bus.rd_en && !empty_w;
        // A simultaneous pop frees the slot, so a full FIFO can still accept.
        do_push     = push_req && (!full_w || do_pop);
        ov_set      = push_req && full_w && !do_pop;
        wr_ptr_d    = wr_ptr_q + PW'(do_push);
        rd_ptr_d    = rd_ptr_q + PW'(do_pop);
        // Set has priority over clear in the same cycle.
        frame_err_d = stop_bad ? 1'b1 : (bus.clear_err ? 1'b0 : frame_err_q);
        overrun_d   = ov_set   ? 1'b1 : (bus.clear_err ? 1'b0 : overrun_q);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            state_q     <= state_d;
            timer_q     <= timer_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // Storage array carries no reset; contents are only visible when !empty.
    always_ff @(posedge clk) begin
        if (rst && do_push) begin
            mem_q[wr_ptr_q[PW-2:0]] <= shift_q;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.data_out  = mem_q[rd_ptr_q[PW-2:0]];
    assign bus.empty     = empty_w;
    assign bus.full      = full_w;
    assign bus.count     = wr_ptr_q - rd_ptr_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_buffered_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_buffered_uart_rx
// Description : Self-checking bench for buffered_uart_rx. A table of line
//               actions with expected FIFO/flag state, followed by directed
//               sequences for fill/overrun, pointer wrap and mid-frame reset.
//               Runs at 16 clocks per bit to keep the frame count affordable.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_buffered_uart_rx;

    localparam int CLK_HZ = 48000000;
    localparam int BAUD   = 3000000;
    localparam int CPB    = CLK_HZ / BAUD;   // 16
    localparam int DL2    = 4;
    localparam int DEPTH  = 1 << DL2;

    // Posedge index (from the start-bit edge) on which the stop bit is sampled:
    // 2 sync + half bit (8) + 9 bit periods.
    localparam int STOP_SAMPLE = 2 + CPB / 2 + 9 * CPB;

    localparam int K_SEND   = 0;
    localparam int K_POP    = 1;
    localparam int K_CLEAR  = 2;
    localparam int K_GLITCH = 3;
    localparam int K_BREAK  = 4;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         exp_count;
        logic [7:0] exp_head;
        logic       exp_fe;
        logic       exp_ov;
    } vec_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;
    vec_t vecs [10];

    buffered_uart_rx_if #(.DEPTH_LOG2(DL2)) bus ();

    buffered_uart_rx #(
        .CLK_HZ     (CLK_HZ),
        .BAUD       (BAUD),
        .DEPTH_LOG2 (DL2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string nm, input int cnt, input logic fe, input logic ov);
        chk({nm, ".count"},     32'(bus.count),     32'(cnt));
        chk({nm, ".empty"},     32'(bus.empty),     32'(cnt == 0));
        chk({nm, ".full"},      32'(bus.full),      32'(cnt == DEPTH));
        chk({nm, ".frame_err"}, 32'(bus.frame_err), 32'(fe));
        chk({nm, ".overrun"},   32'(bus.overrun),   32'(ov));
    endtask

    task automatic idle_line(input logic v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.uart_rx   = v;
            bus.rd_en     = 1'b0;
            bus.clear_err = 1'b0;
        end
    endtask

    // Drives one 10-bit frame; rd_en is raised only for line-cycle pop_at.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int pop_at);
        logic [9:0] bits;
        bits = {stop_v, d, 1'b0};
        for (int k = 0; k < 10 * CPB; k++) begin
            @(negedge clk);
            bus.uart_rx = bits[k / CPB];
            bus.rd_en   = (k == pop_at);
        end
    endtask

    task automatic pulse_pop;
        @(negedge clk);
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic pulse_clear;
        @(negedge clk);
        bus.clear_err = 1'b1;
        @(negedge clk);
        bus.clear_err = 1'b0;
    endtask

    task automatic pop_check(input string nm, input logic [7:0] exp);
        chk(nm, 32'(bus.data_out), 32'(exp));
        pulse_pop();
    endtask

    initial begin
        n_checks      = 0;
        n_err         = 0;
        rst           = 1'b0;
        bus.uart_rx   = 1'b1;
        bus.rd_en     = 1'b0;
        bus.clear_err = 1'b0;

        vecs[0] = '{K_SEND,   8'hA5, 1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{K_POP,    8'h00, 0, 8'h00, 1'b0, 1'b0};
        vecs[2] = '{K_GLITCH, 8'h00, 0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{K_SEND,   8'h12, 1, 8'h12, 1'b0, 1'b0};
        vecs[4] = '{K_BREAK,  8'h3C, 1, 8'h12, 1'b1, 1'b0};
        vecs[5] = '{K_SEND,   8'h7E, 2, 8'h12, 1'b1, 1'b0};
        vecs[6] = '{K_CLEAR,  8'h00, 2, 8'h12, 1'b0, 1'b0};
        vecs[7] = '{K_POP,    8'h00, 1, 8'h7E, 1'b0, 1'b0};
        vecs[8] = '{K_POP,    8'h00, 0, 8'h00, 1'b0, 1'b0};
        vecs[9] = '{K_POP,    8'h00, 0, 8'h00, 1'b0, 1'b0};

        // Reset state
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_state("reset", 0, 1'b0, 1'b0);

        // Table-driven single actions
        for (int i = 0; i < 10; i++) begin
            case (vecs[i].kind)
                K_SEND: begin
                    send_frame(vecs[i].data, 1'b1, -1);
                    idle_line(1'b1, 2);
                end
                K_POP:    pulse_pop();
                K_CLEAR:  pulse_clear();
                K_GLITCH: begin
                    idle_line(1'b0, 4);
                    idle_line(1'b1, 3 * CPB);
                end
                K_BREAK: begin
                    send_frame(vecs[i].data, 1'b0, -1);
                    idle_line(1'b0, 200);
                    idle_line(1'b1, 3 * CPB);
                end
                default: ;
            endcase
            chk_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_fe, vecs[i].exp_ov);
            if (vecs[i].exp_count != 0)
                chk($sformatf("vec%0d.head", i), 32'(bus.data_out), 32'(vecs[i].exp_head));
        end

        // Fill 16 back-to-back, then overrun with no read
        for (int i = 0; i < DEPTH; i++) send_frame(8'(i), 1'b1, -1);
        idle_line(1'b1, 2);
        chk_state("fill16", 16, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, -1);
        idle_line(1'b1, 2);
        chk_state("overrun", 16, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH; i++) pop_check($sformatf("drain%0d", i), 8'(i));
        chk_state("drained", 0, 1'b0, 1'b1);
        pulse_clear();
        chk_state("ov_clear", 0, 1'b0, 1'b0);

        // Second burst after pointer wrap
        for (int i = 0; i < 5; i++) send_frame(8'h20 + 8'(i), 1'b1, -1);
        idle_line(1'b1, 2);
        chk_state("burst5", 5, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) pop_check($sformatf("burst%0d", i), 8'h20 + 8'(i));
        chk_state("burst_done", 0, 1'b0, 1'b0);

        // Full FIFO with a pop in the exact push cycle: no overrun
        for (int i = 0; i < DEPTH; i++) send_frame(8'h30 + 8'(i), 1'b1, -1);
        idle_line(1'b1, 2);
        chk_state("refill", 16, 1'b0, 1'b0);
        send_frame(8'h55, 1'b1, STOP_SAMPLE);
        idle_line(1'b1, 2);
        chk_state("push_pop", 16, 1'b0, 1'b0);
        for (int i = 1; i < DEPTH; i++) pop_check($sformatf("pp%0d", i), 8'h30 + 8'(i));
        pop_check("pp_last", 8'h55);
        chk_state("pp_done", 0, 1'b0, 1'b0);

        // Reset mid-frame with bytes queued and frame_err set
        send_frame(8'hC3, 1'b0, -1);
        idle_line(1'b1, 3 * CPB);
        send_frame(8'h11, 1'b1, -1);
        send_frame(8'h22, 1'b1, -1);
        idle_line(1'b1, 2);
        chk_state("pre_rst", 2, 1'b1, 1'b0);
        for (int k = 0; k < 5 * CPB; k++) begin
            @(negedge clk);
            bus.uart_rx = (k < CPB) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle_line(1'b1, 3 * CPB);
        chk_state("post_rst", 0, 1'b0, 1'b0);
        send_frame(8'h81, 1'b1, -1);
        idle_line(1'b1, 2);
        chk_state("after_rst", 1, 1'b0, 1'b0);
        chk("after_rst.head", 32'(bus.data_out), 32'h81);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
